// File: rtl/shared_reg_pkg.sv
// Shared definitions for the one-byte shared register agents.
//   DATA_W     : width of the shared register data path (reader and writer).
//   rd_state_t : reader handshake states.
package shared_reg_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2
  } rd_state_t;

endpackage

// File: rtl/shared_reg_reader.sv
// Read-side agent for the one-byte shared register.
// Runs the level-based read handshake (raise rd, hold, drop, wait for
// has_data to fall), then re-presents the byte on a valid/ready stream.
// Ports:
//   clk, rst            : clock (rising edge), async active-high reset
//   has_data, rd_data   : shared register status and data
//   rd                  : registered read request to the shared register
//   out_valid, out_data : downstream byte, held while out_valid=1
//   out_ready           : downstream accept
//   byte_count          : completed reads, wraps modulo 2^CW
//   err, clr_err        : sticky protocol error and its synchronous clear
module shared_reg_reader
  import shared_reg_pkg::*;
#(
  parameter int unsigned RD_HOLD = 1,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CW      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              has_data,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CW-1:0]     byte_count,
  output logic              err,
  input  logic              clr_err
);

  localparam int unsigned HOLD_W = (RD_HOLD > 1) ? $clog2(RD_HOLD) : 1;
  localparam int unsigned TO_W   = $clog2(TIMEOUT);

  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RD_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]   TO_ONE    = TO_W'(1);
  localparam logic [CW-1:0]     CNT_ONE   = CW'(1);

  rd_state_t          state, state_n;
  logic               rd_n;
  logic [DATA_W-1:0]  cap, cap_n;
  logic [HOLD_W-1:0]  hold_cnt, hold_n;
  logic [TO_W-1:0]    to_cnt, to_n;
  logic               ov_n;
  logic [DATA_W-1:0]  od_n;
  logic [CW-1:0]      bc_n;
  logic               err_set;
  logic               err_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rd         <= 1'b0;
      cap        <= '0;
      hold_cnt   <= '0;
      to_cnt     <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      byte_count <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      rd         <= rd_n;
      cap        <= cap_n;
      hold_cnt   <= hold_n;
      to_cnt     <= to_n;
      out_valid  <= ov_n;
      out_data   <= od_n;
      byte_count <= bc_n;
      err        <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    rd_n    = rd;
    cap_n   = cap;
    hold_n  = hold_cnt;
    to_n    = to_cnt;
    ov_n    = out_valid;
    od_n    = out_data;
    bc_n    = byte_count;
    err_set = 1'b0;

    // out_valid is only ever set from RELEASE, where it is already low,
    // so the consume clear and the set can never collide.
    if (out_valid && out_ready) begin
      ov_n = 1'b0;
    end

    case (state)
      IDLE: begin
        // Testing the registered out_valid delays a new read to the cycle
        // after the downstream consume.
        if (has_data && !out_valid) begin
          rd_n    = 1'b1;
          cap_n   = rd_data;
          hold_n  = HOLD_INIT;
          state_n = ASSERT;
        end
      end
      ASSERT: begin
        if (!has_data) begin
          err_set = 1'b1;
        end
        if (hold_cnt != '0) begin
          hold_n = hold_cnt - HOLD_ONE;
        end else begin
          rd_n    = 1'b0;
          to_n    = '0;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        if (!has_data) begin
          od_n    = cap;
          ov_n    = 1'b1;
          bc_n    = byte_count + CNT_ONE;
          state_n = IDLE;
        end else if (to_cnt == TO_LAST) begin
          // Timeout: the captured byte is dropped without counting it.
          err_set = 1'b1;
          state_n = IDLE;
        end else begin
          to_n = to_cnt + TO_ONE;
        end
      end
      default: begin
        rd_n    = 1'b0;
        state_n = IDLE;
      end
    endcase

    err_n = err_set | (err & ~clr_err);
  end

endmodule

// File: tb/tb_shared_reg_reader.sv
module tb_shared_reg_reader;
  import shared_reg_pkg::*;

  localparam int TO = 16;

  typedef enum int {M_CONF, M_EARLY, M_STUCK} mode_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] has_data = '0;
  logic [1:0] rd;
  logic [1:0] out_valid;
  logic [1:0] out_ready = '0;
  logic [1:0] err;
  logic [1:0] clr_err = '0;
  logic [7:0] rd_data [2];
  logic [7:0] out_data [2];
  logic [3:0] bc_a;
  logic [15:0] bc_b;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Instance 0: RD_HOLD=1, 4-bit counter. Instance 1: RD_HOLD=4.
  shared_reg_reader #(.RD_HOLD(1), .TIMEOUT(TO), .CW(4)) dut_a (
    .clk(clk), .rst(rst), .has_data(has_data[0]), .rd_data(rd_data[0]),
    .rd(rd[0]), .out_valid(out_valid[0]), .out_data(out_data[0]),
    .out_ready(out_ready[0]), .byte_count(bc_a), .err(err[0]),
    .clr_err(clr_err[0])
  );

  shared_reg_reader #(.RD_HOLD(4), .TIMEOUT(TO), .CW(16)) dut_b (
    .clk(clk), .rst(rst), .has_data(has_data[1]), .rd_data(rd_data[1]),
    .rd(rd[1]), .out_valid(out_valid[1]), .out_data(out_data[1]),
    .out_ready(out_ready[1]), .byte_count(bc_b), .err(err[1]),
    .clr_err(clr_err[1])
  );

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic int get_bc(input int i);
    return (i == 0) ? int'(bc_a) : int'(bc_b);
  endfunction

  // Shared register model: offered bytes, handshake behaviour per mode,
  // and the queue of bytes that must come out downstream, in order.
  mode_t      mode [2];
  logic [7:0] offer_mem [2][64];
  logic [5:0] owp [2] = '{6'd0, 6'd0};
  logic [5:0] orp [2] = '{6'd0, 6'd0};
  logic [7:0] exp_mem [2][64];
  logic [5:0] ewp [2] = '{6'd0, 6'd0};
  logic [5:0] erp [2] = '{6'd0, 6'd0};
  logic [1:0] rd_s;
  logic       seen [2];
  int         stuck_k [2];

  always @(negedge clk) rd_s <= rd;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        has_data[i] = 1'b0;
        orp[i] = owp[i];
        seen[i] = 1'b0;
        stuck_k[i] = 0;
      end else if (!has_data[i]) begin
        if (orp[i] != owp[i]) begin
          rd_data[i] = offer_mem[i][orp[i]];
          orp[i] = orp[i] + 6'd1;
          has_data[i] = 1'b1;
          seen[i] = 1'b0;
          stuck_k[i] = 0;
        end
      end else begin
        case (mode[i])
          M_CONF: begin
            if (rd_s[i]) seen[i] = 1'b1;
            else if (seen[i]) begin
              has_data[i] = 1'b0;
              exp_mem[i][ewp[i]] = rd_data[i];
              ewp[i] = ewp[i] + 6'd1;
            end
          end
          M_EARLY: begin
            if (rd_s[i]) begin
              has_data[i] = 1'b0;
              exp_mem[i][ewp[i]] = rd_data[i];
              ewp[i] = ewp[i] + 6'd1;
            end
          end
          default: begin
            if (rd_s[i]) seen[i] = 1'b1;
            else if (seen[i]) begin
              stuck_k[i]++;
              if (stuck_k[i] == TO) has_data[i] = 1'b0;
            end
          end
        endcase
      end
    end
  end

  // Per-cycle compare against the stream rules and the expected byte queue.
  int         ecnt [2];
  logic       prev_ov [2];
  logic       prev_hs [2];
  logic [7:0] prev_data [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        chk("reset_rd", int'(rd[i]), 0);
        chk("reset_out_valid", int'(out_valid[i]), 0);
        chk("reset_out_data", int'(out_data[i]), 0);
        chk("reset_byte_count", get_bc(i), 0);
        chk("reset_err", int'(err[i]), 0);
        erp[i] = ewp[i];
        ecnt[i] = 0;
        prev_ov[i] = 1'b0;
        prev_hs[i] = 1'b0;
        prev_data[i] = 8'h00;
      end else begin
        chk("rd_while_valid", int'(rd[i] & out_valid[i]), 0);
        if (prev_hs[i]) chk("valid_clear_on_accept", int'(out_valid[i]), 0);
        else if (prev_ov[i]) chk("valid_hold", int'(out_valid[i]), 1);
        if (out_valid[i] && prev_ov[i] && !prev_hs[i])
          chk("data_hold", int'(out_data[i]), int'(prev_data[i]));
        if (out_valid[i] && (!prev_ov[i] || prev_hs[i])) begin
          if (erp[i] == ewp[i]) chk("unexpected_byte", 1, 0);
          else begin
            chk("byte_data", int'(out_data[i]), int'(exp_mem[i][erp[i]]));
            erp[i] = erp[i] + 6'd1;
          end
          ecnt[i]++;
        end
        chk("byte_count", get_bc(i), ecnt[i] & ((i == 0) ? 'hF : 'hFFFF));
        prev_ov[i] = out_valid[i];
        prev_hs[i] = out_valid[i] & out_ready[i];
        prev_data[i] = out_data[i];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic offer(input int i, input logic [7:0] b);
    offer_mem[i][owp[i]] = b;
    owp[i] = owp[i] + 6'd1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    mode[0] = M_CONF;
    mode[1] = M_CONF;
    tick();
  endtask

  // Observation window results.
  int         o_rd_first, o_rd_high, o_rd_rises, o_max_run;
  int         o_fall_first, o_ov_first, o_err_first;
  logic [7:0] del [32];
  int         ndel;

  task automatic observe(input int i, input int n);
    logic prev_rd;
    int   run;
    o_rd_first = -1; o_rd_high = 0; o_rd_rises = 0; o_max_run = 0;
    o_fall_first = -1; o_ov_first = -1; o_err_first = -1;
    ndel = 0;
    run = 0;
    prev_rd = rd[i];
    for (int c = 1; c <= n; c++) begin
      if (out_valid[i] && out_ready[i] && ndel < 32) begin
        del[ndel] = out_data[i];
        ndel++;
      end
      tick();
      if (rd[i]) begin
        o_rd_high++;
        run++;
        if (run > o_max_run) o_max_run = run;
        if (!prev_rd) begin
          o_rd_rises++;
          if (o_rd_first < 0) o_rd_first = c;
        end
      end else begin
        if (prev_rd && o_fall_first < 0) o_fall_first = c;
        run = 0;
      end
      if (out_valid[i] && o_ov_first < 0) o_ov_first = c;
      if (err[i] && o_err_first < 0) o_err_first = c;
      prev_rd = rd[i];
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  initial begin
    bit found;
    mode[0] = M_CONF;
    mode[1] = M_CONF;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("post_reset_rd", int'(rd[0]), 0);
    chk("post_reset_valid", int'(out_valid[0]), 0);
    chk("post_reset_count", get_bc(0), 0);
    chk("post_reset_err", int'(err[0]), 0);

    // Single byte, RD_HOLD=1
    out_ready[0] = 1'b1;
    offer(0, 8'hA5);
    observe(0, 20);
    chk("t1_rd_high_cycles", o_rd_high, 1);
    chk("t1_valid_latency", o_ov_first - o_rd_first, 3);
    chk("t1_deliveries", ndel, 1);
    chk("t1_data", int'(del[0]), 'hA5);
    chk("t1_count", get_bc(0), 1);
    chk("t1_err", int'(err[0]), 0);

    // Backpressure
    reset_dut();
    out_ready[0] = 1'b0;
    offer(0, 8'h11);
    offer(0, 8'h22);
    observe(0, 20);
    chk("t2_one_read_only", o_rd_rises, 1);
    chk("t2_no_delivery", ndel, 0);
    chk("t2_valid_pending", int'(out_valid[0]), 1);
    chk("t2_data_pending", int'(out_data[0]), 'h11);
    chk("t2_second_waiting", int'(has_data[0]), 1);
    out_ready[0] = 1'b1;
    observe(0, 20);
    chk("t2_deliveries", ndel, 2);
    chk("t2_first", int'(del[0]), 'h11);
    chk("t2_second", int'(del[1]), 'h22);
    chk("t2_second_read", o_rd_rises, 1);
    chk("t2_count", get_bc(0), 2);

    // RD_HOLD=4
    reset_dut();
    out_ready[1] = 1'b1;
    offer(1, 8'h3C);
    offer(1, 8'hC3);
    observe(1, 40);
    chk("t3_reads", o_rd_rises, 2);
    chk("t3_rd_high_total", o_rd_high, 8);
    chk("t3_rd_run", o_max_run, 4);
    chk("t3_deliveries", ndel, 2);
    chk("t3_first", int'(del[0]), 'h3C);
    chk("t3_second", int'(del[1]), 'hC3);
    chk("t3_count", get_bc(1), 2);

    // Timeout
    reset_dut();
    mode[0] = M_STUCK;
    offer(0, 8'h5A);
    observe(0, 40);
    chk("t4_reads", o_rd_rises, 1);
    chk("t4_err_delay", o_err_first - o_fall_first, TO);
    chk("t4_no_valid", o_ov_first, -1);
    chk("t4_count", get_bc(0), 0);
    chk("t4_err_sticky", int'(err[0]), 1);
    clr_err[0] = 1'b1;
    tick();
    clr_err[0] = 1'b0;
    chk("t4_err_cleared", int'(err[0]), 0);

    // Early drop, then set-over-clear priority
    reset_dut();
    mode[1] = M_EARLY;
    offer(1, 8'h96);
    observe(1, 40);
    chk("t5_err", int'(err[1]), 1);
    chk("t5_deliveries", ndel, 1);
    chk("t5_data", int'(del[0]), 'h96);
    chk("t5_count", get_bc(1), 1);
    clr_err[1] = 1'b1;
    tick();
    chk("t5_err_cleared", int'(err[1]), 0);
    offer(1, 8'h69);
    observe(1, 40);
    chk("t5_set_beats_clear", int'(o_err_first > 0), 1);
    chk("t5_err_after_clear", int'(err[1]), 0);
    chk("t5_data2", int'(del[0]), 'h69);
    chk("t5_count2", get_bc(1), 2);
    clr_err[1] = 1'b0;

    // Reset mid-read
    reset_dut();
    offer(0, 8'h10);
    observe(0, 12);
    chk("t6_count_before", get_bc(0), 1);
    offer(0, 8'h77);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (rd[0]) found = 1'b1;
    end
    chk("t6_read_started", int'(found), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rd_async", int'(rd[0]), 0);
    chk("t6_data_async", int'(out_data[0]), 0);
    chk("t6_count_async", get_bc(0), 0);
    tick();
    tick();
    rst = 1'b0;
    observe(0, 10);
    chk("t6_byte_lost", o_rd_rises, 0);

    // Counter wrap, CW=4
    reset_dut();
    for (int k = 0; k < 17; k++) offer(0, 8'(k * 3 + 1));
    observe(0, 160);
    chk("t7_deliveries", ndel, 17);
    chk("t7_last", int'(del[16]), 49);
    chk("t7_count_wrap", get_bc(0), 1);

    tick();
    chk("drained_a", int'(ewp[0] == erp[0]), 1);
    chk("drained_b", int'(ewp[1] == erp[1]), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
